// File: rtl/comparador_serial_pkg.sv
// comparador_serial_pkg: shared state encoding and default geometry for the serial comparator
package comparador_serial_pkg;
  localparam int CMP_WIDTH = 32;
  localparam int CMP_DIGIT = 8;
  localparam int CMP_NDIG = CMP_WIDTH / CMP_DIGIT;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int CMP_IDX_W = idx_w(CMP_NDIG);
  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_SCAN = 2'd1,
    CMP_DONE = 2'd2
  } cmp_state_e;
endpackage

// File: rtl/comparador_serial_if.sv
// comparador_serial_if: start/busy/done handshake plus operands and results
interface comparador_serial_if
  import comparador_serial_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signo;
  logic             busy;
  logic             done;
  logic             menor;
  logic             igual;
  modport master(output start, a, b, signo, input busy, done, menor, igual);
  modport slave(input start, a, b, signo, output busy, done, menor, igual);
endinterface

// File: rtl/comparador_digito.sv
// comparador_digito: combinational unsigned compare of one digit
module comparador_digito #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o
);
  assign lt_o = a_i < b_i;
  assign eq_o = a_i == b_i;
endmodule

// File: rtl/comparador_serial.sv
// comparador_serial: set-less-than comparator scanning one digit per clock, MS digit first,
// stopping at the first digit that differs.
module comparador_serial
  import comparador_serial_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int DIGIT = CMP_DIGIT
) (
  input logic                clk,
  input logic                reset_n,
  comparador_serial_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW = idx_w(NDIG);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             menor_q, menor_d, igual_q, igual_d;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             lt, eq, accept, last;
  assign a_dig = DIGIT'(a_q >> (DIGIT * (NDIG - 1 - int'(idx_q))));
  assign b_dig = DIGIT'(b_q >> (DIGIT * (NDIG - 1 - int'(idx_q))));
  comparador_digito #(.DIGIT(DIGIT)) u_dig (
    .a_i (a_dig),
    .b_i (b_dig),
    .lt_o(lt),
    .eq_o(eq)
  );
  assign accept = bus.start && state_q != CMP_SCAN;
  assign last   = idx_q == IW'(NDIG - 1);
  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    menor_d = menor_q;
    igual_d = igual_q;
    if (accept) begin
      a_d     = bus.a ^ (bus.signo ? MSB : '0);
      b_d     = bus.b ^ (bus.signo ? MSB : '0);
      idx_d   = '0;
      state_d = CMP_SCAN;
    end else if (state_q == CMP_SCAN) begin
      state_d = (!eq || last) ? CMP_DONE : CMP_SCAN;
      idx_d   = (!eq || last) ? idx_q : idx_q + 1'b1;
      menor_d = (!eq || last) ? lt : menor_q;
      igual_d = (!eq || last) ? eq : igual_q;
    end else if (state_q == CMP_DONE) begin
      state_d = CMP_IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CMP_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      menor_q <= 1'b0;
      igual_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      menor_q <= menor_d;
      igual_q <= igual_d;
    end
  end
  assign bus.busy  = state_q == CMP_SCAN;
  assign bus.done  = state_q == CMP_DONE;
  assign bus.menor = menor_q;
  assign bus.igual = igual_q;
endmodule

// File: tb/tb_comparador_serial.sv
// tb_comparador_serial: directed vectors with literal expectations plus a per-cycle
// behavioural model comparing handshake and results on every falling edge.
module tb_comparador_serial;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  comparador_serial_if #(.WIDTH(32)) bus ();
  comparador_serial #(.WIDTH(32), .DIGIT(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_diff(input logic [31:0] x, input logic [31:0] y);
    for (int i = 0; i < 4; i++)
      if (((x >> (24 - 8 * i)) & 32'hFF) != ((y >> (24 - 8 * i)) & 32'hFF)) return i + 1;
    return 4;
  endfunction

  // Model: an accepted compare keeps busy for k cycles, then done pulses with the results
  int   left = 0;
  logic m_done = 1'b0, m_menor = 1'b0, m_igual = 1'b0, p_menor = 1'b0, p_igual = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left    <= 0;
      m_done  <= 1'b0;
      m_menor <= 1'b0;
      m_igual <= 1'b0;
    end else begin
      m_done <= left == 1;
      left   <= left > 0 ? left - 1 : (bus.start ? first_diff(bus.a, bus.b) : 0);
      if (left == 1) begin
        m_menor <= p_menor;
        m_igual <= p_igual;
      end
      if (left == 0 && bus.start) begin
        p_menor <= bus.signo ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
        p_igual <= bus.a == bus.b;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_busy", 32'(bus.busy), 32'(left > 0));
    chk("model_done", 32'(bus.done), 32'(m_done));
    chk("model_menor", 32'(bus.menor), 32'(m_menor));
    chk("model_igual", 32'(bus.igual), 32'(m_igual));
  end

  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.signo = sv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    bus.signo = ~sv;
  endtask

  task automatic wait_done(input string nm, input logic em, input logic ei, input int ek,
                           input int c0);
    int cyc = c0;
    while (!bus.done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_k"}, 32'(cyc - 1), 32'(ek));
    chk({nm, "_menor"}, 32'(bus.menor), 32'(em));
    chk({nm, "_igual"}, 32'(bus.igual), 32'(ei));
    chk({nm, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.signo = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_menor", 32'(bus.menor), 32'd0);
    chk("rst_igual", 32'(bus.igual), 32'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    launch(32'd5, 32'd7, 1'b0);
    wait_done("u5lt7", 1'b1, 1'b0, 4, 1);
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_done("s_m1lt1", 1'b1, 1'b0, 1, 1);
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done("u_maxgt1", 1'b0, 1'b0, 1, 1);
    @(negedge clk);
    launch(32'h1234_5678, 32'h1234_5678, 1'b1);
    wait_done("s_equal", 1'b0, 1'b1, 4, 1);
    @(negedge clk);
    launch(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    wait_done("s_minlt", 1'b1, 1'b0, 1, 1);
    launch(32'd3, 32'd2, 1'b0);
    chk("b2b_no_idle", 32'(bus.busy), 32'd1);
    chk("b2b_hold_menor", 32'(bus.menor), 32'd1);
    wait_done("b2b_3gt2", 1'b0, 1'b0, 4, 1);
    @(negedge clk);
    launch(32'd5, 32'd7, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("retrig", 1'b1, 1'b0, 4, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_menor", 32'(bus.menor), 32'd1);
      chk("hold_done", 32'(bus.done), 32'd0);
    end
    launch(32'd5, 32'd7, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_menor", 32'(bus.menor), 32'd0);
    chk("arst_igual", 32'(bus.igual), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(bus.done), 32'd0);
    end
    launch(32'h0000_0100, 32'h0000_00FF, 1'b0);
    wait_done("post_rst", 1'b0, 1'b0, 3, 1);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/comparador_serial.md
# comparador_serial

Multi-cycle set-less-than comparator for the MIPS execute stage. It compares two 32-bit operands MSB-digit first, one digit per clock, and stops at the first differing digit. Its registered 1-bit `menor` result feeds the 1-bit zero-extension stage that forms the 32-bit SLT/SLTU/SLTI/SLTIU writeback value. A start/busy/done handshake lets the control unit stall while a compare is in flight.

## Interface
- `WIDTH`, 32, operand width in bits; must be a multiple of `DIGIT`
- `DIGIT`, 8, bits compared per cycle; must be ≥1. `NDIG = WIDTH/DIGIT` (4 by default)
- `clk`  input  1  clock; all state changes on the rising edge
- `reset_n`  input  1  reset, asynchronous and active-low
- `start`  input  1  request a compare; sampled on the rising edge of `clk`
- `a`  input  WIDTH  operand rs; captured when `start` is accepted
- `b`  input  WIDTH  operand rt or immediate; captured when `start` is accepted
- `signo`  input  1  1 = signed compare (SLT/SLTI), 0 = unsigned (SLTU/SLTIU); captured when `start` is accepted
- `busy`  output  1  high while a compare is in flight
- `done`  output  1  one-cycle pulse; results are valid from this cycle onward
- `menor`  output  1  a < b under the selected signedness; goes to the zero-extend stage
- `igual`  output  1  a == b

## Operation
- **States:** IDLE, SCAN, DONE. Reset puts the block in IDLE.
- **Reset values:** `busy=0`, `done=0`, `menor=0`, `igual=0`. Digit index = 0.
- **Start acceptance:** `start` is accepted in IDLE or DONE. On acceptance:
  - Latch `a` and `b`. If `signo=1`, invert bit WIDTH-1 of both latched operands, which turns the signed order into an unsigned order.
  - Set digit index to 0 (the MS digit) and go to SCAN.
- **Start while in SCAN:** ignored. The latched operands do not change.
- **Each SCAN cycle:** compare digit `idx` (bits `WIDTH-1-idx*DIGIT` down to `WIDTH-DIGIT-idx*DIGIT`) as unsigned values.
  - Digits differ: register `menor = (a_d < b_d)`, `igual = 0`, go to DONE.
  - Digits equal and `idx == NDIG-1`: register `menor = 0`, `igual = 1`, go to DONE.
  - Otherwise: increment `idx` and stay in SCAN.
- **DONE:** lasts exactly one cycle. Without `start`, go to IDLE.
- **Result hold:** `menor` and `igual` hold their values through IDLE until the next decision. They are not cleared when `start` is accepted.
- **Width rule:** digit compare is `DIGIT`-bit unsigned. No arithmetic subtraction is used, so there is no carry/overflow path.

## Timing
- `busy` is high in SCAN only. `done` is high in DONE only. All outputs are registered.
- **Latency:** with `start` accepted at edge E0, the decision edge is E_k, where k is the 1-based position of the first differing digit (k = NDIG when all digits are equal). `done` is high for the cycle after E_k. Range is 1..NDIG cycles.
- **Back-to-back:** `start` asserted during the DONE cycle is accepted. SCAN follows immediately with no IDLE bubble.
- **Reset mid-SCAN:** asynchronous return to IDLE; all outputs return to their reset values immediately. No `done` is produced for the aborted compare.
- **Input changes:** `a`, `b` and `signo` may change freely after acceptance without affecting the result.

## Structure
- **Shared package/include:**
  - state encoding constants `CMP_IDLE`, `CMP_SCAN`, `CMP_DONE` (2-bit)
  - the default `WIDTH`/`DIGIT` values
  - the derived `NDIG` and index width `$clog2(NDIG)`
- **Sub-module `comparador_digito`:** combinational, `DIGIT`-bit unsigned compare producing `lt` and `eq`. Instantiated once and fed by a digit-select mux.
- **Top level:** FSM, operand registers, index counter and result registers.

## Test plan
- `a=5`, `b=7`, `signo=0` -> `menor=1`, `igual=0`; `done` one cycle after E4; `busy` high for 4 cycles.
- `a=0xFFFFFFFF`, `b=1`, `signo=1` -> `menor=1` at k=1. Same operands with `signo=0` -> `menor=0` at k=1.
- `a=b=0x12345678`, `signo=1` -> `menor=0`, `igual=1`, k=4. Then `a=0x80000000`, `b=0x7FFFFFFF`, `signo=1` -> `menor=1`, k=1.
- `start` pulsed again at cycle 2 of SCAN with different operands -> ignored; the result reflects the first operands. Results hold through 3 idle cycles.
- `start` asserted in the DONE cycle with `a=3`, `b=2`, `signo=0` -> SCAN on the next edge, `menor=0` at k=4; no IDLE cycle between the two compares.
- `reset_n` asserted low mid-SCAN (between clock edges) -> `busy`, `done`, `menor` and `igual` go to 0 immediately; no `done` after release; a fresh `start` works normally.
